kbd_media_ctrl: RTL

//  Parametrised keyboard-driven playback controller. Decodes ASCII key codes from the PS/2 front end

---
 rtl/kbd_media_if.sv | 28 ++
 rtl/kbd_media_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/kbd_media_if.sv
// Keyboard command inputs and playback address/status outputs of the media controller.
// Master drives keys and sample ticks; slave (the controller) returns the address stream and status.
interface kbd_media_if #(
  parameter int ADDR_W = 23,
  parameter int SPD_W  = 4
);
  logic [7:0]        ascii_code;
  logic              code_valid;
  logic              sample_tick;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              playing;
  logic              forward;
  logic              loop_en;
  logic [SPD_W-1:0]  speed_div;
  logic              restart;
  logic              end_hit;

  modport master (
    output ascii_code, code_valid, sample_tick,
    input  addr, addr_valid, playing, forward, loop_en, speed_div, restart, end_hit
  );

  modport slave (
    input  ascii_code, code_valid, sample_tick,
    output addr, addr_valid, playing, forward, loop_en, speed_div, restart, end_hit
  );
endinterface

// File: rtl/kbd_media_ctrl.sv
// Keyboard-driven playback controller: key codes -> transport state, sample_tick -> address stream.
// Latency: command effect 2 edges after code_valid rises, advance 1 edge after tick; no backpressure.
module kbd_media_ctrl #(
  parameter int          ADDR_W     = 23,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 'h7FFFF,
  parameter int          SPD_W      = 4,
  parameter int unsigned DIV_INIT   = 0
) (
  input logic         clk,
  input logic         rst_n,
  kbd_media_if.slave  bus
);
  typedef enum logic [1:0] {PAUSED, PLAYING, ENDED} state_t;

  localparam logic [ADDR_W-1:0] WIN_LO  = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] WIN_HI  = ADDR_W'(END_ADDR);
  localparam logic [SPD_W-1:0]  DIV_RST = SPD_W'(DIV_INIT);
  localparam logic [SPD_W-1:0]  DIV_MAX = '1;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              fwd_q, fwd_n;
  logic              loop_q, loop_n;
  logic [SPD_W-1:0]  div_q, div_n;
  logic [SPD_W-1:0]  cnt_q, cnt_n;
  logic              av_q, av_n;
  logic              rs_q, rs_n;
  logic              eh_q, eh_n;
  logic              code_valid_q, cmd_q;
  logic [7:0]        key_q;

  logic key_e, key_d, key_f, key_b, key_r, key_l, key_plus, key_minus;
  logic do_restart;

  always_comb begin
    key_e     = (key_q == 8'h45) || (key_q == 8'h65);
    key_d     = (key_q == 8'h44) || (key_q == 8'h64);
    key_f     = (key_q == 8'h46) || (key_q == 8'h66);
    key_b     = (key_q == 8'h42) || (key_q == 8'h62);
    key_r     = (key_q == 8'h52) || (key_q == 8'h72);
    key_l     = (key_q == 8'h4C) || (key_q == 8'h6C);
    key_plus  = (key_q == 8'h2B);
    key_minus = (key_q == 8'h2D);
    do_restart = cmd_q && (key_r || (key_e && state_q == ENDED));
  end

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    fwd_n   = fwd_q;
    loop_n  = loop_q;
    div_n   = div_q;
    cnt_n   = cnt_q;
    av_n    = 1'b0;
    rs_n    = 1'b0;
    eh_n    = 1'b0;

    // Tick uses pre-command direction/divider/state; a restart discards it.
    if (state_q == PLAYING && bus.sample_tick && !do_restart) begin
      if (cnt_q == div_q) begin
        cnt_n = '0;
        if (fwd_q ? (addr_q == WIN_HI) : (addr_q == WIN_LO)) begin
          if (loop_q) begin
            addr_n = fwd_q ? WIN_LO : WIN_HI;
            av_n   = 1'b1;
          end else begin
            state_n = ENDED;
            eh_n    = 1'b1;
          end
        end else begin
          addr_n = fwd_q ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
          av_n   = 1'b1;
        end
      end else begin
        cnt_n = cnt_q + SPD_W'(1);
      end
    end

    if (do_restart) begin
      addr_n  = fwd_q ? WIN_LO : WIN_HI;
      cnt_n   = '0;
      av_n    = 1'b1;
      rs_n    = 1'b1;
      if (state_q == ENDED) state_n = key_e ? PLAYING : PAUSED;
    end else if (cmd_q) begin
      if (key_e && state_q == PAUSED)  state_n = PLAYING;
      if (key_d && state_q == PLAYING) state_n = PAUSED;
      if (key_f)     fwd_n  = 1'b1;
      if (key_b)     fwd_n  = 1'b0;
      if (key_l)     loop_n = ~loop_q;
      if (key_plus)  div_n  = (div_q == '0) ? '0 : div_q - SPD_W'(1);
      if (key_minus) div_n  = (div_q == DIV_MAX) ? DIV_MAX : div_q + SPD_W'(1);
    end

    // Shrinking the divider below the running count restarts the count.
    if (cnt_n > div_n) cnt_n = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PAUSED;
      addr_q       <= WIN_LO;
      fwd_q        <= 1'b1;
      loop_q       <= 1'b1;
      div_q        <= DIV_RST;
      cnt_q        <= '0;
      av_q         <= 1'b0;
      rs_q         <= 1'b0;
      eh_q         <= 1'b0;
      code_valid_q <= 1'b0;
      cmd_q        <= 1'b0;
      key_q        <= 8'h00;
    end else begin
      state_q      <= state_n;
      addr_q       <= addr_n;
      fwd_q        <= fwd_n;
      loop_q       <= loop_n;
      div_q        <= div_n;
      cnt_q        <= cnt_n;
      av_q         <= av_n;
      rs_q         <= rs_n;
      eh_q         <= eh_n;
      code_valid_q <= bus.code_valid;
      cmd_q        <= bus.code_valid & ~code_valid_q;
      key_q        <= bus.ascii_code;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = av_q;
  assign bus.playing    = (state_q == PLAYING);
  assign bus.forward    = fwd_q;
  assign bus.loop_en    = loop_q;
  assign bus.speed_div  = div_q;
  assign bus.restart    = rs_q;
  assign bus.end_hit    = eh_q;
endmodule
